pe_dot_sequencer: RTL and testbench
===================================

// Module: pe_dot_sequencer
// PURPOSE
//   Sequences one multiply-accumulate processing element (PE) through a
//   dot product. The PE computes result <= result + floatA*floatB on every
//   clock and is cleared while its reset is high.
//   On start, this block accepts LEN IEEE-754 single operand pairs over a
//   valid/ready stream and feeds them to the PE. It waits for the PE
//   pipeline to drain, then returns the accumulated sum on a valid/ready
//   output.
//   It sits between the conv-layer operand fetch and the PE instance.
// PARAMETERS
//   LEN_W   16  width of len and of the internal accept counter
//   PE_LAT  1   clock edges after operands reach the PE inputs before
//               pe_result includes them
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; whole block to reset state
//   start      in   1      begin a job; sampled only in IDLE
//   len        in   LEN_W  number of operand pairs; latched with start
//   abort      in   1      synchronous; discard the job, return to IDLE
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operand pair accepted when in_valid & in_ready
//   in_a       in   32     operand A (float32)
//   in_b       in   32     operand B (float32)
//   pe_reset   out  1      drives PE reset; high = accumulator cleared
//   pe_floatA  out  32     registered operand A to the PE
//   pe_floatB  out  32     registered operand B to the PE
//   pe_result  in   32     PE accumulator output
//   out_valid  out  1      sum available
//   out_ready  in   1      consumer takes the sum when out_valid & out_ready
//   out_data   out  32     accumulated sum (float32)
//   busy       out  1      high in every state except IDLE
// BEHAVIOUR
//   Reset values:
//     pe_reset=1; pe_floatA=pe_floatB=0; in_ready=0; out_valid=0;
//     out_data=0; busy=0; state=IDLE.
//   States: IDLE, STREAM, DRAIN, DONE. All registered except in_ready,
//     which is combinational: in_ready = (state==STREAM).
//   IDLE:
//     - pe_reset=1; PE inputs driven with 0.
//     - start & len!=0: latch len into len_q, clear cnt, pe_reset<=0, go to STREAM.
//     - start & len==0: out_data<=0, go to DONE.
//   STREAM:
//     - Handshake: pe_floatA/B <= in_a/in_b and cnt++.
//     - No handshake: pe_floatA/B <= 0. A 0*0 bubble adds +0.0 and leaves
//       the sum unchanged.
//     - Handshake with cnt==len_q-1: go to DRAIN and load drain counter dc<=PE_LAT.
//   DRAIN:
//     - PE inputs <= 0; dc decrements each cycle.
//     - When dc==0: out_data<=pe_result, pe_reset<=1, go to DONE.
//     - Duration: DRAIN lasts exactly PE_LAT+1 cycles, so out_valid rises
//       PE_LAT+2 edges after the last-pair handshake.
//   DONE:
//     - out_valid=1; out_data and out_valid are held stable while
//       out_ready=0. pe_reset stays 1.
//     - out_ready: out_valid<=0, go to IDLE. A start is ignored until
//       IDLE is reached.
//   start while not IDLE: ignored; len is not re-latched.
//   abort (any state except IDLE):
//     - Next state IDLE; pe_reset<=1; PE inputs <= 0; out_valid<=0.
//     - No sum is produced.
//     - Abort has priority over a same-cycle handshake, DRAIN capture or
//       out_ready.
//   Asynchronous reset mid-job: all outputs take their reset values
//     immediately, without waiting for a clock edge. The job is lost.
//   cnt is LEN_W bits and never wraps, because len_q <= 2^LEN_W-1.
//   No arithmetic is done in this block. Float values pass through unmodified.
// TESTING
//   1. PE_LAT=1, len=2, pairs (0x40000000,0x40400000) then
//      (0x3F800000,0x40A00000) back-to-back -> out_data=0x41300000 (11.0).
//      out_valid rises 3 edges after the 2nd handshake.
//   2. len=3, three pairs of 1.0*1.0 with in_valid low 2 cycles between
//      pairs -> in_ready stays 1 and PE inputs are 0 in the gaps;
//      out_data=0x40400000.
//   3. start with len=0 -> next cycle out_valid=1 and out_data=0;
//      pe_reset never deasserts; in_ready stays 0.
//   4. Hold out_ready=0 for 5 cycles in DONE and pulse start -> out_valid
//      and out_data stay stable, start is ignored; out_ready=1 -> IDLE
//      next cycle.
//   5. len=4, abort after the 1st pair -> IDLE, pe_reset=1, no out_valid.
//      Then len=1 with (2.0,3.0) -> out_data=0x40C00000 (accumulator was
//      cleared).
//   6. Assert reset mid-STREAM between clock edges -> pe_reset=1,
//      in_ready=0, busy=0 immediately. After release, a len=1 job
//      completes normally.

Source files
------------

// File: rtl/pe_dot_sequencer.sv
// Streams LEN float32 operand pairs into a MAC PE, waits PE_LAT+1 drain cycles, then returns the sum.
// Input stalls whenever the block is outside STREAM; the result is held in DONE until out_ready.
module pe_dot_sequencer #(
    parameter int LEN_W  = 16,
    parameter int PE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             pe_reset,
    output logic [31:0]      pe_floatA,
    output logic [31:0]      pe_floatB,
    input  logic [31:0]      pe_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy
);

    localparam int DC_W = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       out_dat_q, out_dat_d;
    logic              pe_rst_q, pe_rst_d;
    logic              out_vld_q, out_vld_d;
    logic              hs;

    assign in_ready  = (state_q == STREAM);
    assign hs        = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign pe_reset  = pe_rst_q;
    assign pe_floatA = a_q;
    assign pe_floatB = b_q;
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        dc_d      = dc_q;
        a_d       = 32'h0;
        b_d       = 32'h0;
        pe_rst_d  = pe_rst_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        case (state_q)
            IDLE: begin
                pe_rst_d = 1'b1;
                if (start) begin
                    if (len != '0) begin
                        len_d    = len;
                        cnt_d    = '0;
                        pe_rst_d = 1'b0;
                        state_d  = STREAM;
                    end else begin
                        out_dat_d = 32'h0;
                        out_vld_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            STREAM: begin
                // Idle cycles feed 0*0 so the accumulator is unaffected.
                if (hs) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        dc_d    = DC_W'(PE_LAT);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dc_q == '0) begin
                    out_dat_d = pe_result;
                    out_vld_d = 1'b1;
                    pe_rst_d  = 1'b1;
                    state_d   = DONE;
                end else begin
                    dc_d = dc_q - DC_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any same-cycle handshake, capture or output transfer.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            pe_rst_d  = 1'b1;
            a_d       = 32'h0;
            b_d       = 32'h0;
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            dc_q      <= '0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            pe_rst_q  <= 1'b1;
            out_vld_q <= 1'b0;
            out_dat_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dc_q      <= dc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pe_rst_q  <= pe_rst_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Directed bench for pe_dot_sequencer with a behavioural single-cycle MAC PE and an output scoreboard.
module tb_pe_dot_sequencer;

    localparam int LEN_W  = 16;
    localparam int PE_LAT = 1;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F11 = 32'h41300000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = 32'h0;
    logic [31:0]      in_b = 32'h0;
    logic             pe_reset;
    logic [31:0]      pe_floatA, pe_floatB;
    logic [31:0]      pe_result;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [31:0] exp_q[$];
    real acc = 0.0;

    pe_dot_sequencer #(.LEN_W(LEN_W), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pe_reset(pe_reset), .pe_floatA(pe_floatA), .pe_floatB(pe_floatB),
        .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(int'(f[22:0])) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real    x;
        int     e;
        logic   s;
        longint mant;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        x = s ? -v : v;
        e = 127;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        mant = longint'((x - 1.0) * 8388608.0);
        return {s, e[7:0], mant[22:0]};
    endfunction

    // Behavioural PE: one-edge MAC latency, synchronous clear.
    always @(posedge clk) begin
        if (pe_reset) acc <= 0.0;
        else          acc <= acc + f2r(pe_floatA) * f2r(pe_floatB);
    end
    always_comb pe_result = r2f(acc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%08h with no job pending", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
            n_out++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        int   budget;
        logic hs;
        budget   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        do begin
            hs = in_ready;
            tick();
            budget++;
        end while (!hs && budget < 50);
        in_valid = 1'b0;
        chk("handshake_seen", {31'h0, hs}, 32'h1);
        chk("pe_floatA", pe_floatA, a);
        chk("pe_floatB", pe_floatB, b);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("gap_in_ready", {31'h0, in_ready}, 32'h1);
            chk("gap_floatA", pe_floatA, 32'h0);
            chk("gap_floatB", pe_floatB, 32'h0);
        end
    endtask

    // Counts edges from the last handshake edge (counted as 1) until out_valid.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("out_valid_seen", {31'h0, out_valid}, 32'h1);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("rst_floatA", pe_floatA, 32'h0);
        chk("rst_floatB", pe_floatB, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Two back-to-back pairs: 2*3 + 1*5 = 11
        exp_q.push_back(F11);
        start_job(16'd2);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        send_pair(F2, F3);
        send_pair(F1, F5);
        wait_out(n);
        chk("t1_latency", n, PE_LAT + 2);
        tick();
        chk("t1_idle", {31'h0, busy}, 32'h0);

        // Gapped stream: 1*1 three times = 3
        exp_q.push_back(F3);
        start_job(16'd3);
        send_pair(F1, F1);
        gap(2);
        send_pair(F1, F1);
        gap(2);
        send_pair(F1, F1);
        wait_out(n);
        chk("t2_latency", n, PE_LAT + 2);
        tick();

        // Zero-length job
        exp_q.push_back(32'h0);
        start_job(16'd0);
        chk("t3_out_valid", {31'h0, out_valid}, 32'h1);
        chk("t3_out_data", out_data, 32'h0);
        chk("t3_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("t3_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        chk("t3_pe_reset2", {31'h0, pe_reset}, 32'h1);
        chk("t3_idle", {31'h0, busy}, 32'h0);

        // Held output with ignored start
        out_ready = 1'b0;
        exp_q.push_back(F4);
        start_job(16'd1);
        send_pair(F2, F2);
        wait_out(n);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 16'd5;
            tick();
            chk("t4_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("t4_hold_data", out_data, F4);
            chk("t4_pe_reset", {31'h0, pe_reset}, 32'h1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_idle", {31'h0, busy}, 32'h0);
        chk("t4_valid_low", {31'h0, out_valid}, 32'h0);
        tick();
        chk("t4_no_restart", {31'h0, busy}, 32'h0);

        // Abort mid-stream, then a fresh job must see a cleared accumulator
        start_job(16'd4);
        send_pair(F1, F1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_idle", {31'h0, busy}, 32'h0);
        chk("t5_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("t5_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_floatA", pe_floatA, 32'h0);
        tick();
        exp_q.push_back(F6);
        start_job(16'd1);
        send_pair(F2, F3);
        wait_out(n);
        tick();

        // Asynchronous reset between edges
        start_job(16'd3);
        send_pair(F1, F1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("t6_in_ready", {31'h0, in_ready}, 32'h0);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_floatA", pe_floatA, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        exp_q.push_back(F5);
        start_job(16'd1);
        send_pair(F1, F5);
        wait_out(n);
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("pending_results", exp_q.size(), 32'h0);
        chk("result_count", n_out, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
